voice_iq_fifo: RTL and testbench

// - Buffers decimated RX voice I/Q pairs between the DDC output and the STM32 bus interface.
// - Absorbs jitter between the DDC's voice strobe and the MCU's RX IQ bursts (DATA_SYNC command 4).
// - Drives VOICE_I/VOICE_Q from the FIFO head; the interface pops one pair per burst.
// - Reports fill level and sticky overflow/underflow flags for the SEND PARAMS status bytes.

---
 rtl/voice_iq_fifo_if.sv | 49 ++++
 rtl/voice_iq_fifo.sv | 134 +++++++++++++
 tb/tb_voice_iq_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/voice_iq_fifo_if.sv
// ============================================================================
// Module   : voice_iq_fifo_if
// Brief    : DDC-side push, bus-side pop and status signals of the voice I/Q FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface voice_iq_fifo_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
);
  logic [WIDTH-1:0]      IN_I;
  logic [WIDTH-1:0]      IN_Q;
  logic                  in_valid;
  logic                  rd_req;
  logic                  flush;
  logic [WIDTH-1:0]      VOICE_I;
  logic [WIDTH-1:0]      VOICE_Q;
  logic                  out_valid;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  underflow;
  logic [7:0]            drop_cnt;
`ifdef VOICE_FIFO_WM_EN
  logic                  wm_irq;
`endif

  // Driven by the DDC and the bus interface.
  modport master (
    output IN_I, output IN_Q, output in_valid, output rd_req, output flush,
    input  VOICE_I, input VOICE_Q, input out_valid, input level,
    input  overflow, input underflow, input drop_cnt
`ifdef VOICE_FIFO_WM_EN
    , input wm_irq
`endif
  );

  // Seen from the FIFO itself.
  modport slave (
    input  IN_I, input IN_Q, input in_valid, input rd_req, input flush,
    output VOICE_I, output VOICE_Q, output out_valid, output level,
    output overflow, output underflow, output drop_cnt
`ifdef VOICE_FIFO_WM_EN
    , output wm_irq
`endif
  );
endinterface

`default_nettype wire

// File: rtl/voice_iq_fifo.sv
// ============================================================================
// Module   : voice_iq_fifo
// Brief    : Voice I/Q pair FIFO between the DDC and the MCU bus interface,
//            with sticky overflow/underflow flags and a saturating drop count.
//            Optional watermark flag wm_irq when VOICE_FIFO_WM_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module voice_iq_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16,
  parameter int WM_LEVEL   = 12
) (
  input  wire             clk_in,
  input  wire             reset_n,
  voice_iq_fifo_if.slave  bus
);

  localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [2*WIDTH-1:0]    mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [7:0]            drop_cnt_q;

  logic                  empty;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;
  logic                  drop;
  logic                  under;

  // Out-of-range parameters leave this marker block in the elaborated hierarchy.
  generate
    if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8 || WM_LEVEL < 0) begin : g_param_illegal
    end
  endgenerate

  assign empty = (level_q == '0);
  assign full  = (level_q == c_FULL_LEVEL);

  // A pop on empty is ignored; a push on full is accepted only alongside a pop.
  assign do_pop  = bus.rd_req & ~empty;
  assign do_push = bus.in_valid & (~full | do_pop);
  assign drop    = bus.in_valid & full & ~bus.rd_req;
  assign under   = bus.rd_req & empty;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
      if (under) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (do_push && !bus.flush) begin
      mem_q[wr_ptr_q] <= {bus.IN_I, bus.IN_Q};
    end
  end

  assign bus.VOICE_I   = empty ? '0 : mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign bus.VOICE_Q   = empty ? '0 : mem_q[rd_ptr_q][WIDTH-1:0];
  assign bus.out_valid = ~empty;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

`ifdef VOICE_FIFO_WM_EN
  localparam logic [DEPTH_LOG2+1:0] c_WM_LEVEL = (DEPTH_LOG2+2)'(WM_LEVEL);

  logic wm_irq_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wm_irq_q <= 1'b0;
    end else if (bus.flush) begin
      wm_irq_q <= 1'b0;
    end else begin
      wm_irq_q <= ({1'b0, level_d} >= c_WM_LEVEL);
    end
  end

  assign bus.wm_irq = wm_irq_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_voice_iq_fifo.sv
// ============================================================================
// Module   : tb_voice_iq_fifo
// Brief    : Directed self-checking bench for voice_iq_fifo (depth 16, 16-bit).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_voice_iq_fifo;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;
  int   n_err   = 0;
  int   n_chk   = 0;
  logic [31:0] model [$];
  logic [31:0] head;

  always #5 clk_in = ~clk_in;

  voice_iq_fifo_if #(.DEPTH_LOG2(4), .WIDTH(16)) bus ();

  voice_iq_fifo #(
    .DEPTH_LOG2 (4),
    .WIDTH      (16),
    .WM_LEVEL   (12)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic [15:0] vi, input logic [15:0] vq,
                      input logic pv, input logic prd, input logic pfl);
    bus.IN_I     = vi;
    bus.IN_Q     = vq;
    bus.in_valid = pv;
    bus.rd_req   = prd;
    bus.flush    = pfl;
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    bus.IN_I = '0; bus.IN_Q = '0; bus.in_valid = 1'b0; bus.rd_req = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;

    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", {bus.VOICE_I, bus.VOICE_Q}, 32'h0);
    chk("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);

    // Single pair latency and sign of Q.
    step(16'h1234, 16'hFFFB, 1'b1, 1'b0, 1'b0);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data", {bus.VOICE_I, bus.VOICE_Q}, 32'h1234FFFB);
    chk("first_level", 32'(bus.level), 32'd1);
    step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("pop_level", 32'(bus.level), 32'd0);
    chk("pop_empty_data", {bus.VOICE_I, bus.VOICE_Q}, 32'h0);

    // Fill to 16.
    for (int k = 1; k <= 16; k++) step(16'(16'h0100 + k), 16'(16'h0200 + k), 1'b1, 1'b0, 1'b0);
    chk("full_level", 32'(bus.level), 32'd16);
    chk("full_head", {bus.VOICE_I, bus.VOICE_Q}, 32'h01010201);

    // Full with push+pop: pair 1 leaves, 0x0AAA/0x0555 enters, no drop.
    step(16'h0AAA, 16'h0555, 1'b1, 1'b1, 1'b0);
    chk("fullpp_level", 32'(bus.level), 32'd16);
    chk("fullpp_ovf", 32'(bus.overflow), 32'd0);
    chk("fullpp_drop", 32'(bus.drop_cnt), 32'd0);

    // 17th push with no pop is dropped.
    step(16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_drop", 32'(bus.drop_cnt), 32'd1);

    for (int k = 2; k <= 16; k++) begin
      chk("drain_head", {bus.VOICE_I, bus.VOICE_Q}, {16'(16'h0100 + k), 16'(16'h0200 + k)});
      step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_last", {bus.VOICE_I, bus.VOICE_Q}, 32'h0AAA0555);
    step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_level", 32'(bus.level), 32'd0);
    chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("drain_no_under", 32'(bus.underflow), 32'd0);

    // Pop on empty.
    step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("under_flag", 32'(bus.underflow), 32'd1);
    chk("under_level", 32'(bus.level), 32'd0);
    step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
    chk("flush_drop", 32'(bus.drop_cnt), 32'd0);

    // Push+pop on empty: push wins, underflow raised.
    step(16'h7777, 16'h8888, 1'b1, 1'b1, 1'b0);
    chk("epp_level", 32'(bus.level), 32'd1);
    chk("epp_under", 32'(bus.underflow), 32'd1);
    chk("epp_data", {bus.VOICE_I, bus.VOICE_Q}, 32'h77778888);

    // Flush overrides a simultaneous push.
    step(16'h5555, 16'h6666, 1'b1, 1'b0, 1'b1);
    chk("flushpush_level", 32'(bus.level), 32'd0);
    chk("flushpush_valid", 32'(bus.out_valid), 32'd0);
    chk("flushpush_under", 32'(bus.underflow), 32'd0);

    // 20 pushes with pops on odd cycles, crossing the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      if (i[0]) begin
        head = model.pop_front();
        chk("wrap_head", {bus.VOICE_I, bus.VOICE_Q}, head);
      end
      model.push_back({16'(16'h3000 + i), 16'(16'h4000 + i)});
      step(16'(16'h3000 + i), 16'(16'h4000 + i), 1'b1, i[0], 1'b0);
    end
    chk("wrap_level", 32'(bus.level), 32'd10);
    while (model.size() > 0) begin
      head = model.pop_front();
      chk("wrap_drain", {bus.VOICE_I, bus.VOICE_Q}, head);
      step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_empty", 32'(bus.level), 32'd0);

    // Drop counter saturation.
    for (int k = 0; k < 16; k++) step(16'(k), 16'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 254; k++) step(16'hEEEE, 16'hEEEE, 1'b1, 1'b0, 1'b0);
    chk("drop_254", 32'(bus.drop_cnt), 32'd254);
    for (int k = 0; k < 46; k++) step(16'hEEEE, 16'hEEEE, 1'b1, 1'b0, 1'b0);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);
    chk("drop_level", 32'(bus.level), 32'd16);
    chk("drop_head", {bus.VOICE_I, bus.VOICE_Q}, 32'h00000000 | {16'h0, 16'h0});
    step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("drop_second", {bus.VOICE_I, bus.VOICE_Q}, 32'h00010001);

    // Asynchronous reset mid-run empties the FIFO without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("async_level", 32'(bus.level), 32'd0);
    chk("async_drop", 32'(bus.drop_cnt), 32'd0);
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk_in);
    #1 reset_n = 1'b1;

`ifdef VOICE_FIFO_WM_EN
    for (int k = 0; k < 11; k++) step(16'(k), 16'(k), 1'b1, 1'b0, 1'b0);
    chk("wm_11", 32'(bus.wm_irq), 32'd0);
    step(16'h000B, 16'h000B, 1'b1, 1'b0, 1'b0);
    chk("wm_12", 32'(bus.wm_irq), 32'd1);
    step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("wm_pop11", 32'(bus.wm_irq), 32'd0);
    step(16'h000C, 16'h000C, 1'b1, 1'b0, 1'b0);
    chk("wm_back12", 32'(bus.wm_irq), 32'd1);
    step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("wm_flush", {bus.wm_irq, 23'd0, bus.level}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
